// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared definitions for the write-back select stage.
//   - wb_sel_e  : source-select encodings for the write-back mux.
//   - wb_beat_t : one write-back beat (data, rd, qualified we, sel_err) at the
//                 default 32-bit datapath width.
//   - wb_qual_we: x0 write suppression helper.
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WB_XLEN  = 32;
  localparam int unsigned WB_SEL_W = 3;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_SEL_ALU   = 3'd0,
    WB_SEL_LOAD  = 3'd1,
    WB_SEL_PC4   = 3'd2,
    WB_SEL_PCIMM = 3'd3,
    WB_SEL_IMM   = 3'd4
  } wb_sel_e;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd;
    logic               we;
    logic               sel_err;
  } wb_beat_t;

  // Writes to x0 are dropped but the beat itself still flows downstream.
  function automatic logic wb_qual_we(input logic we, input logic [4:0] rd);
    return we & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// ---------------------------------------------------------------------------
// wb_skid_buffer
//   Generic valid/ready register stage for a beat of type beat_t.
//   Configuration macro: WB_SKID_EN
//     defined   : 2-entry skid buffer, in_ready is a register output
//                 (= skid entry empty); one extra beat is absorbed when
//                 out_ready falls.
//     undefined : single output register, in_ready = ~out_valid | out_ready.
//   flush invalidates every held beat and discards the beat on the input.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush (priority over accept/transfer)
//   in_valid/in_ready   upstream handshake, in_beat payload
//   out_valid/out_ready downstream handshake, out_beat payload
// ---------------------------------------------------------------------------
module wb_skid_buffer
  import wb_pkg::*;
#(
  parameter type beat_t = wb_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  beat_t out_beat_q, out_beat_d;
  logic  out_valid_q, out_valid_d;

`ifdef WB_SKID_EN
  beat_t skid_beat_q, skid_beat_d;
  logic  skid_valid_q, skid_valid_d;
  logic  accept;
  logic  out_free;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  // Output slot is either empty or emptying at this edge.
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_beat_d   = out_beat_q;
    out_valid_d  = out_valid_q;
    skid_beat_d  = skid_beat_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // A full skid entry blocks accept, so only one source can feed out.
      if (skid_valid_q) begin
        out_beat_d   = skid_beat_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_beat_d = in_beat;
      end
    end else if (accept) begin
      skid_beat_d  = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_beat_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_beat_q  <= skid_beat_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;

  always_comb begin
    out_beat_d  = out_beat_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_ready) begin
      out_valid_d = in_valid;
      if (in_valid) out_beat_d = in_beat;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_beat_q  <= out_beat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_beat  = out_beat_q;

endmodule

// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//   Registered write-back select stage between MEM and the register file.
//   Selects one of NUM_SRC packed sources, qualifies the write enable against
//   x0, flags illegal selects, and registers the beat through wb_skid_buffer.
//   Also counts beats retired downstream.
//   Configuration macro: WB_SKID_EN (see wb_skid_buffer) selects a 2-entry
//   skid buffer instead of a single output register.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous pipeline flush
//   in_valid/in_ready    upstream handshake
//   in_data              NUM_SRC*XLEN packed sources, source k at [k*XLEN +: XLEN]
//   in_sel/in_rd/in_we   source index, destination register, write request
//   out_valid/out_ready  downstream handshake
//   out_data/out_rd/out_we  selected result, destination, qualified write enable
//   sel_err              beat at output had in_sel >= NUM_SRC
//   retire_cnt           beats transferred downstream, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [4:0]              in_rd,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [4:0]              out_rd,
  output logic                    out_we,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        retire_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
    logic            sel_err;
  } stage_beat_t;

  logic [31:0]     sel_ext;
  logic [XLEN-1:0] sel_data;
  logic            sel_bad;
  stage_beat_t     in_beat;
  stage_beat_t     out_beat;
  logic            xfer;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign sel_ext = 32'(in_sel);
  assign sel_bad = (sel_ext >= NUM_SRC);

  // Illegal selects fall through to zero data.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_ext == k) sel_data = in_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    in_beat         = '0;
    in_beat.data    = sel_data;
    in_beat.rd      = in_rd;
    in_beat.we      = wb_qual_we(in_we, in_rd);
    in_beat.sel_err = sel_bad;
  end

  wb_skid_buffer #(
    .beat_t (stage_beat_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_beat   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat)
  );

  // A beat leaving in the flush cycle is killed, so it is not retired.
  assign xfer         = out_valid & out_ready & ~flush;
  assign retire_cnt_d = xfer ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign out_data   = out_beat.data;
  assign out_rd     = out_beat.rd;
  assign out_we     = out_beat.we;
  assign sel_err    = out_beat.sel_err;
  assign retire_cnt = retire_cnt_q;

endmodule
